// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the integer register-file write side.
//   XLEN       data width
//   NREG       number of architectural registers
//   REG_AW     register address width
//   wb_entry_t one pending write {rd, data}
//   rdMask()   one-hot register mask of rd, with x0 never marked
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // x0 is hardwired to zero, so a write to it never needs tracking.
  function automatic logic [NREG-1:0] rdMask(input logic [REG_AW-1:0] rd);
    logic [NREG-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    m[0]  = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous in-order FIFO of wb_entry_t holding buffered load results.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (pointers/count cleared)
//   i_push          write i_pushEntry at the tail (caller guarantees not full)
//   i_pushEntry     entry to write
//   i_pop           drop the head entry (caller guarantees not empty)
//   o_head          current head entry
//   o_count         occupancy, 0..DEPTH
//   o_pendMask      OR of one-hot rd masks of every valid entry
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  wb_entry_t       i_pushEntry,
  input  logic            i_pop,
  output wb_entry_t       o_head,
  output logic [AW:0]     o_count,
  output logic [NREG-1:0] o_pendMask
);

  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [NREG-1:0] w_pendMask;

  // Storage carries no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_pushEntry;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk the occupied window starting at the head.
  always_comb begin
    w_pendMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < r_count) begin
        w_pendMask = w_pendMask | rdMask(r_mem[r_rptr + AW'(i)].rd);
      end
    end
  end

  assign o_head     = r_mem[r_rptr];
  assign o_count    = r_count;
  assign o_pendMask = w_pendMask;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side front end of the integer register file.
// Accepts ALU results (single cycle) and load results (buffered in wb_fifo),
// picks one winner per cycle and registers it onto the regfile write port.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   ld_valid/ld_ready/ld_rd/ld_data       load result handshake
//   rf_we/rf_waddr/rf_wdata           registered regfile write port
//   rs1_addr/rs2_addr                 decode-stage read addresses
//   pend_mask                         registers with a write buffered or in output stage
//   ld_count                          load FIFO occupancy
//   fwd1_hit/fwd1_data/fwd2_hit/fwd2_data  forwarding of the in-flight write
// Configuration macro: WB_FWD_EN enables forwarding; otherwise fwd ports are 0.
module regfile_writeback
  import rv_pkg::*;
#(
  parameter int LD_DEPTH = 4,
  parameter int CW       = $clog2(LD_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [NREG-1:0]   pend_mask,
  output logic [CW-1:0]     ld_count,
  output logic              fwd1_hit,
  output logic [XLEN-1:0]   fwd1_data,
  output logic              fwd2_hit,
  output logic [XLEN-1:0]   fwd2_data
);

  wb_entry_t         w_head;
  wb_entry_t         w_winner;
  logic [CW-1:0]     w_count;
  logic [NREG-1:0]   w_fifoMask;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_win;
  logic              r_we;
  logic [REG_AW-1:0] r_waddr;
  logic [XLEN-1:0]   r_wdata;

  // Readiness comes only from the registered count, never from valid or pop.
  assign w_full    = (w_count == CW'(LD_DEPTH));
  assign w_empty   = (w_count == '0);
  assign ld_ready  = !w_full;
  assign alu_ready = !w_full;
  assign w_push    = ld_valid && ld_ready;

  wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pushEntry ({ld_rd, ld_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_pendMask  (w_fifoMask)
  );

  // A full FIFO takes priority so loads cannot starve behind a busy ALU.
  always_comb begin
    w_win    = 1'b0;
    w_pop    = 1'b0;
    w_winner = '0;
    if (w_full) begin
      w_win    = 1'b1;
      w_pop    = 1'b1;
      w_winner = w_head;
    end else if (alu_valid) begin
      w_win    = 1'b1;
      w_winner = {alu_rd, alu_data};
    end else if (!w_empty) begin
      w_win    = 1'b1;
      w_pop    = 1'b1;
      w_winner = w_head;
    end
  end

  // Writes to x0 are consumed but never raise the write enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_win && (w_winner.rd != '0);
      if (w_win) begin
        r_waddr <= w_winner.rd;
        r_wdata <= w_winner.data;
      end
    end
  end

  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign ld_count  = w_count;
  assign pend_mask = w_fifoMask | (r_we ? rdMask(r_waddr) : '0);

`ifdef WB_FWD_EN
  // Lets decode read the value being written this cycle.
  assign fwd1_hit  = r_we && (r_waddr != '0) && (r_waddr == rs1_addr);
  assign fwd2_hit  = r_we && (r_waddr != '0) && (r_waddr == rs2_addr);
  assign fwd1_data = r_wdata;
  assign fwd2_data = r_wdata;
`else
  logic w_unusedRs;
  assign w_unusedRs = ^{rs1_addr, rs2_addr};
  assign fwd1_hit   = 1'b0;
  assign fwd2_hit   = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed plus randomized stimulus for regfile_writeback,
// checked every cycle against a queue-based reference of the writeback rules.
// Honours WB_FWD_EN the same way as the design.
module tb_regfile_writeback;
  import rv_pkg::*;

  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic              clk;
  logic              rst_n;
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [NREG-1:0]   pend_mask;
  logic [CW-1:0]     ld_count;
  logic              fwd1_hit;
  logic [XLEN-1:0]   fwd1_data;
  logic              fwd2_hit;
  logic [XLEN-1:0]   fwd2_data;

  regfile_writeback #(.LD_DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .pend_mask (pend_mask),
    .ld_count  (ld_count),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: buffered loads in arrival order plus the write port.
  wb_entry_t         q[$];
  logic              mWe;
  logic [REG_AW-1:0] mWaddr;
  logic [XLEN-1:0]   mWdata;
  bit                modelValid;
  int                checks;
  int                errors;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] expPend();
    logic [NREG-1:0] m;
    m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    if (mWe) m[mWaddr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic checkOutput();
    logic expHit1;
    logic expHit2;
    logic [XLEN-1:0] expFd;
`ifdef WB_FWD_EN
    expHit1 = mWe && (mWaddr != 0) && (mWaddr == rs1_addr);
    expHit2 = mWe && (mWaddr != 0) && (mWaddr == rs2_addr);
    expFd   = mWdata;
`else
    expHit1 = 1'b0;
    expHit2 = 1'b0;
    expFd   = '0;
`endif
    checkValue("rf_we", 64'(rf_we), 64'(mWe));
    checkValue("rf_waddr", 64'(rf_waddr), 64'(mWaddr));
    checkValue("rf_wdata", 64'(rf_wdata), 64'(mWdata));
    checkValue("ld_count", 64'(ld_count), 64'(q.size()));
    checkValue("pend_mask", 64'(pend_mask), 64'(expPend()));
    checkValue("fwd1_hit", 64'(fwd1_hit), 64'(expHit1));
    checkValue("fwd2_hit", 64'(fwd2_hit), 64'(expHit2));
    checkValue("fwd1_data", 64'(fwd1_data), 64'(expFd));
    checkValue("fwd2_data", 64'(fwd2_data), 64'(expFd));
  endtask

  // Drives one cycle, checks readiness before the edge, advances the
  // reference and checks the registered outputs after the edge.
  task automatic applyStimulus(input bit rstn, input bit av, input int ard, input logic [31:0] ad,
                               input bit lv, input int lrd, input logic [31:0] ldat,
                               input int r1, input int r2);
    bit        full;
    bit        win;
    wb_entry_t w;
    wb_entry_t e;
    @(negedge clk);
    rst_n     = rstn;
    alu_valid = av;
    alu_rd    = REG_AW'(ard);
    alu_data  = ad;
    ld_valid  = lv;
    ld_rd     = REG_AW'(lrd);
    ld_data   = ldat;
    rs1_addr  = REG_AW'(r1);
    rs2_addr  = REG_AW'(r2);
    #1;
    if (modelValid) begin
      checkValue("alu_ready", 64'(alu_ready), 64'(q.size() < D));
      checkValue("ld_ready", 64'(ld_ready), 64'(q.size() < D));
    end
    if (!rstn) begin
      q.delete();
      mWe        = 1'b0;
      mWaddr     = '0;
      mWdata     = '0;
      modelValid = 1'b1;
    end else begin
      full = (q.size() >= D);
      win  = 1'b0;
      w    = '0;
      if (full) begin
        w = q.pop_front(); win = 1'b1;
      end else if (av) begin
        w.rd = REG_AW'(ard); w.data = ad; win = 1'b1;
      end else if (q.size() > 0) begin
        w = q.pop_front(); win = 1'b1;
      end
      if (lv && !full) begin
        e.rd = REG_AW'(lrd); e.data = ldat;
        q.push_back(e);
      end
      mWe = win && (w.rd != 0);
      if (win) begin
        mWaddr = w.rd;
        mWdata = w.data;
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    modelValid = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("reset_we", 64'(rf_we), 64'd0);
    checkValue("reset_count", 64'(ld_count), 64'd0);

    // Lone ALU result appears on the write port one cycle later.
    applyStimulus(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    checkValue("alu5_we", 64'(rf_we), 64'd1);
    checkValue("alu5_waddr", 64'(rf_waddr), 64'd5);
    checkValue("alu5_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    checkValue("alu5_pend", 64'(pend_mask[5]), 64'd1);
    idle(1);

    // Fill the FIFO while the ALU keeps winning, then drain it.
    for (int i = 1; i <= 4; i++) applyStimulus(1, 1, 10 + i, 32'h1000 + i, 1, i, 32'h100 + i, 0, 0);
    checkValue("fill_count", 64'(ld_count), 64'd4);
    checkValue("fill_ld_ready", 64'(ld_ready), 64'd0);
    checkValue("fill_alu_ready", 64'(alu_ready), 64'd0);
    applyStimulus(1, 1, 20, 32'h2000, 0, 0, 0, 0, 0);
    checkValue("drain_head_rd", 64'(rf_waddr), 64'd1);
    checkValue("drain_head_data", 64'(rf_wdata), 64'h101);
    applyStimulus(1, 1, 20, 32'h2000, 0, 0, 0, 0, 0);
    idle(4);
    checkValue("drained_count", 64'(ld_count), 64'd0);

    // x0 destination is consumed without a write.
    applyStimulus(1, 1, 0, 32'h1, 0, 0, 0, 0, 0);
    checkValue("x0_we", 64'(rf_we), 64'd0);
    checkValue("x0_pend", 64'(pend_mask), 64'd0);

    // Forwarding of the in-flight write.
    applyStimulus(1, 1, 7, 32'h55, 0, 0, 0, 7, 0);
`ifdef WB_FWD_EN
    checkValue("fwd_rs1_hit", 64'(fwd1_hit), 64'd1);
    checkValue("fwd_rs1_data", 64'(fwd1_data), 64'h55);
    checkValue("fwd_rs2_x0", 64'(fwd2_hit), 64'd0);
`else
    checkValue("nofwd_rs1_hit", 64'(fwd1_hit), 64'd0);
`endif
    idle(1);

    // Push and pop together at occupancy 2.
    applyStimulus(1, 1, 3, 32'h33, 1, 8, 32'h808, 0, 0);
    applyStimulus(1, 1, 3, 32'h34, 1, 9, 32'h909, 0, 0);
    checkValue("pp_pre_count", 64'(ld_count), 64'd2);
    applyStimulus(1, 0, 0, 0, 1, 10, 32'hA0A, 0, 0);
    checkValue("pp_count", 64'(ld_count), 64'd2);
    checkValue("pp_head", 64'(rf_waddr), 64'd8);
    idle(4);

    // Reset discards buffered loads.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 12, 32'hC0 + i, 1, 20 + i, 32'hD0 + i, 0, 0);
    applyStimulus(0, 1, 12, 32'hEE, 1, 25, 32'hEF, 0, 0);
    checkValue("rst_count", 64'(ld_count), 64'd0);
    checkValue("rst_we", 64'(rf_we), 64'd0);
    checkValue("rst_pend", 64'(pend_mask), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 60) != 0, $urandom_range(0, 2) != 0,
                    int'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), $urandom,
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
